// File: rtl/sync_debounce.sv
// sync_debounce: per-channel multi-stage synchroniser followed by a stable-count debouncer
// with registered level and one-cycle rise/fall pulses.
module sync_debounce #(
    parameter int               WIDTH       = 3,
    parameter int               DEPTH       = 3,
    parameter int               STABLE      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] iv_input,
    output logic [WIDTH-1:0] ov_level,
    output logic [WIDTH-1:0] ov_rise,
    output logic [WIDTH-1:0] ov_fall
);
    localparam int CW = STABLE > 1 ? $clog2(STABLE) : 1;
    logic [WIDTH-1:0] sync [DEPTH];
    logic [CW-1:0]    count [WIDTH];
    logic [WIDTH-1:0] s;
    assign s = sync[DEPTH-1];
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) sync[k] <= RESET_VALUE;
            for (int n = 0; n < WIDTH; n++) count[n] <= '0;
            ov_level <= RESET_VALUE;
            ov_rise  <= '0;
            ov_fall  <= '0;
        end else begin
            sync[0] <= iv_input;
            for (int k = 1; k < DEPTH; k++) sync[k] <= sync[k-1];
            for (int n = 0; n < WIDTH; n++) begin
                ov_rise[n] <= 1'b0;
                ov_fall[n] <= 1'b0;
                // a matching sample drops any partial count, so there is no carry-over
                if (s[n] == ov_level[n]) begin
                    count[n] <= '0;
                end else if (count[n] == CW'(STABLE - 1)) begin
                    count[n]    <= '0;
                    ov_level[n] <= s[n];
                    ov_rise[n]  <= s[n];
                    ov_fall[n]  <= ~s[n];
                end else begin
                    count[n] <= count[n] + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: three configurations driven in lockstep; a declarative model pushes
// expected outputs per edge into a scoreboard that a separate monitor pops and compares.
module tb_sync_debounce;
    localparam int NC = 3;
    localparam int MAXE = 4096;
    localparam int DEP [NC] = '{3, 3, 2};
    localparam int STB [NC] = '{4, 4, 1};
    localparam logic [2:0] RV [NC] = '{3'b000, 3'b111, 3'b000};

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic [2:0] iv_input = '0;
    logic [2:0] lv [NC];
    logic [2:0] ri [NC];
    logic [2:0] fa [NC];

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(3), .DEPTH(3), .STABLE(4), .RESET_VALUE(3'b000)) dut0 (
        .i_clk(clk), .i_reset(i_reset), .iv_input(iv_input),
        .ov_level(lv[0]), .ov_rise(ri[0]), .ov_fall(fa[0]));
    sync_debounce #(.WIDTH(3), .DEPTH(3), .STABLE(4), .RESET_VALUE(3'b111)) dut1 (
        .i_clk(clk), .i_reset(i_reset), .iv_input(iv_input),
        .ov_level(lv[1]), .ov_rise(ri[1]), .ov_fall(fa[1]));
    sync_debounce #(.WIDTH(3), .DEPTH(2), .STABLE(1), .RESET_VALUE(3'b000)) dut2 (
        .i_clk(clk), .i_reset(i_reset), .iv_input(iv_input),
        .ov_level(lv[2]), .ov_rise(ri[2]), .ov_fall(fa[2]));

    logic [26:0] sb [$];
    int checks = 0;
    int fails = 0;
    int t = 0;
    logic [2:0] in_h [MAXE];
    bit         rst_h [MAXE];
    logic [2:0] s_h [NC][MAXE];
    logic [2:0] lvl_m [NC];
    int         last_m [NC][3];

    // Synchronised value seen at edge t: the input captured DEPTH edges earlier,
    // unless a reset reloaded the chain somewhere in between.
    // Acceptance: the last STABLE edges since the previous level change or reset all
    // presented a value different from the current level.
    task automatic step(input logic [2:0] in, input bit r);
        logic [26:0] e;
        logic [2:0] s, rr, ff;
        bit ok;
        @(negedge clk);
        iv_input = in;
        i_reset = r;
        in_h[t] = in;
        rst_h[t] = r;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            rr = '0;
            ff = '0;
            if (r) begin
                lvl_m[c] = RV[c];
                s = RV[c];
                for (int n = 0; n < 3; n++) last_m[c][n] = t;
                s_h[c][t] = s;
            end else begin
                if (t < DEP[c]) s = RV[c];
                else s = in_h[t - DEP[c]];
                for (int k = 1; k <= DEP[c]; k++)
                    if (t - k < 0 || rst_h[t - k]) s = RV[c];
                s_h[c][t] = s;
                for (int n = 0; n < 3; n++) begin
                    ok = (t - STB[c] + 1) > last_m[c][n];
                    for (int k = 0; k < STB[c]; k++)
                        if (ok && s_h[c][t - k][n] == lvl_m[c][n]) ok = 0;
                    if (ok) begin
                        rr[n] = s[n];
                        ff[n] = ~s[n];
                        lvl_m[c][n] = s[n];
                        last_m[c][n] = t;
                    end
                end
            end
            e[c*9 +: 9] = {lvl_m[c], rr, ff};
        end
        sb.push_back(e);
        t++;
    endtask

    task automatic hold(input logic [2:0] in, input int cyc);
        for (int i = 0; i < cyc; i++) step(in, 1'b0);
    endtask

    initial begin : monitor
        logic [26:0] e;
        logic [8:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int c = 0; c < NC; c++) begin
                    act = {lv[c], ri[c], fa[c]};
                    checks++;
                    if (act !== e[c*9 +: 9]) begin
                        fails++;
                        $display("FAIL cfg%0d edge%0d level/rise/fall actual %b_%b_%b expected %b_%b_%b",
                                 c, t - 1 - sb.size(), act[8:6], act[5:3], act[2:0],
                                 e[c*9+6 +: 3], e[c*9+3 +: 3], e[c*9 +: 3]);
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [2:0] cur;
        step(3'b000, 1'b1);
        hold(3'b000, 3);
        hold(3'b001, 12);
        hold(3'b000, 12);
        hold(3'b010, 3);
        hold(3'b000, 10);
        hold(3'b101, 12);
        hold(3'b000, 12);
        for (int i = 0; i < 10; i++) step({2'b00, 1'((i / 2) % 2 == 0)}, 1'b0);
        hold(3'b001, 12);
        hold(3'b000, 12);
        hold(3'b100, 5);
        step(3'b100, 1'b1);
        hold(3'b100, 12);
        hold(3'b000, 12);
        step(3'b111, 1'b1);
        hold(3'b111, 12);
        step(3'b000, 1'b1);
        cur = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 3; n++)
                if ($urandom_range(7) == 0) cur[n] = ~cur[n];
            step(cur, $urandom_range(199) == 0);
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: SyncDebounce

Interface
REQ-001 Parameter WIDTH, default 3, number of independent channels; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 3, synchroniser flip-flop stages per channel; SHALL be >= 2.
REQ-003 Parameter STABLE, default 4, consecutive cycles a synchronised value must persist before acceptance; SHALL be >= 1.
REQ-004 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into every synchroniser stage and the debounced level on reset.
REQ-005 i_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 iv_input  input  WIDTH  asynchronous channel inputs.
REQ-008 ov_level  output  WIDTH  debounced, synchronised level per channel, registered.
REQ-009 ov_rise  output  WIDTH  one-cycle pulse per channel when ov_level goes 0->1, registered.
REQ-010 ov_fall  output  WIDTH  one-cycle pulse per channel when ov_level goes 1->0, registered.

Function
REQ-011 Each channel SHALL contain a DEPTH-stage shift chain: stage 0 samples iv_input[n], stage k samples stage k-1; s[n] = stage DEPTH-1.
REQ-012 Each channel SHALL hold a debounce counter of width max(1, clog2(STABLE)), never exceeding STABLE-1.
REQ-013 If s[n] == ov_level[n]: counter SHALL be cleared to 0 at the next edge.
REQ-014 If s[n] != ov_level[n] and counter < STABLE-1: counter SHALL increment by 1.
REQ-015 If s[n] != ov_level[n] and counter == STABLE-1: ov_level[n] SHALL load s[n], counter SHALL clear to 0, and the matching ov_rise[n]/ov_fall[n] SHALL assert on the same edge.
REQ-016 Any return of s[n] to ov_level[n] before acceptance SHALL discard the partial count (no hysteresis carry-over).
REQ-017 ov_rise[n] and ov_fall[n] SHALL be high for exactly one cycle per accepted transition and SHALL never be high simultaneously.
REQ-018 Latency: an input change set up before edge E and held stable SHALL appear on ov_level at edge E+DEPTH+STABLE-1 (DEPTH=3, STABLE=4: 6 edges after first capture, i.e. observable 7 edges after the input is applied mid-cycle).
REQ-019 STABLE=1 SHALL degenerate to acceptance on the first edge where s[n] != ov_level[n].
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce pulses in the same cycle.
REQ-021 No combinational path SHALL exist from iv_input to any output.

Reset
REQ-022 While i_reset is high at an edge: all synchroniser stages and ov_level SHALL load RESET_VALUE, counters SHALL load 0, ov_rise and ov_fall SHALL load 0.
REQ-023 Reset SHALL take priority over all other updates, including an acceptance due on the same edge.
REQ-024 Leaving reset SHALL NOT by itself generate a rise or fall pulse; a post-reset input differing from RESET_VALUE SHALL take the full DEPTH+STABLE-1 acceptance path.
REQ-025 Reset asserted mid-count SHALL abandon the partial count with no pulse.

Verification (WIDTH=3, DEPTH=3, STABLE=4, RESET_VALUE=0 unless stated)
REQ-026 Reset for 1 cycle with iv_input=000 -> ov_level=000, ov_rise=000, ov_fall=000 on the first edge with i_reset high.
REQ-027 iv_input 000->001 held -> ov_level[0] rises at capture edge +6; ov_rise=001 for exactly that one cycle; ov_fall stays 000.
REQ-028 iv_input[1] high for 3 cycles then low -> ov_level, ov_rise, ov_fall stay 000 throughout.
REQ-029 iv_input 000->101 held, later 101->000 held -> ov_rise=101 in one cycle, later ov_fall=101 in one cycle; channel 1 never pulses.
REQ-030 iv_input[0] toggled every 2 cycles for 10 cycles, then held 1 -> exactly one ov_rise[0] pulse, 6 edges after capture of the final transition.
REQ-031 iv_input[2] high for 5 cycles, i_reset pulsed before acceptance, input kept high -> no pulse during reset; ov_level[2] rises 6 edges after the first post-reset capture; RESET_VALUE=111 run with iv_input=111 -> no pulses after reset.
